// File: rtl/game_report_tx_if.sv
// Host-facing report link of game_report_tx: tagged field stream plus the host ack.
interface game_report_tx_if;
    logic [4:0] out_data;
    logic [2:0] out_tag;
    logic       out_valid;
    logic       frame_done;
    logic       game_ready;
    logic       out_parity;
    logic       host_ack;

    modport master (
        output out_data, out_tag, out_valid, frame_done, game_ready, out_parity,
        input  host_ack
    );

    modport slave (
        input  out_data, out_tag, out_valid, frame_done, game_ready, out_parity,
        output host_ack
    );
endinterface

// File: rtl/game_report_tx.sv
// Snapshots game state on new-game / shot triggers and streams it as tagged 5-bit fields,
// one field per host ack edge. Define REPORT_PARITY_EN to drive even parity on out_parity.
module game_report_tx #(
    parameter int SCORE_W     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ena,
    input  logic                    new_game,
    input  logic                    result_valid,
    input  logic                    hit,
    input  logic [4:0]              target_x,
    input  logic [4:0]              target_y,
    input  logic [4:0]              x_pos,
    input  logic [2:0]              aim_pos,
    input  logic [4:0]              tc_pos,
    game_report_tx_if.master        rpt
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    typedef logic [7:0][4:0] frame_t;   // indexed by tag

    localparam logic [SCORE_W-1:0] CNT_ONE = 1;
    localparam logic [SCORE_W-1:0] CNT_MAX = '1;

    state_t                 state;
    frame_t                 frame_q, pend_q, shot_snap, ng_snap, start_src;
    logic                   pend_vld, ng_frame, restart;
    logic [2:0]             idx, last_idx;
    logic [SCORE_W-1:0]     hits, shots, hits_inc, shots_inc;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_q, new_game_q, ng_edge, ack_edge;
    logic [4:0]             out_data;
    logic [2:0]             out_tag;
    logic                   out_valid, frame_done, game_ready;

    function automatic logic [4:0] cnt5(input logic [SCORE_W-1:0] v);
        logic [SCORE_W+4:0] t;
        t = {5'b0, v};
        return t[4:0];
    endfunction

    assign ng_edge   = new_game & ~new_game_q;
    assign ack_edge  = sync_q[SYNC_STAGES-1] & ~ack_q;
    assign shots_inc = (shots == CNT_MAX) ? shots : shots + CNT_ONE;
    assign hits_inc  = (hit && hits != CNT_MAX) ? hits + CNT_ONE : hits;
    assign last_idx  = ng_frame ? 3'd1 : 3'd7;

    // Shot snapshot carries the post-increment scores.
    always_comb begin
        shot_snap    = '0;
        shot_snap[2] = x_pos;
        shot_snap[3] = {2'b0, aim_pos};
        shot_snap[4] = tc_pos;
        shot_snap[5] = {4'b0, hit};
        shot_snap[6] = cnt5(hits_inc);
        shot_snap[7] = cnt5(shots_inc);
        ng_snap      = '0;
        ng_snap[0]   = target_x;
        ng_snap[1]   = target_y;
        start_src    = (state == DONE && !result_valid) ? pend_q : shot_snap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_q    <= '0;
            pend_q     <= '0;
            pend_vld   <= 1'b0;
            ng_frame   <= 1'b0;
            restart    <= 1'b0;
            idx        <= '0;
            hits       <= '0;
            shots      <= '0;
            sync_q     <= '0;
            ack_q      <= 1'b0;
            new_game_q <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            game_ready <= 1'b0;
        end else if (ena) begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rpt.host_ack};
            ack_q      <= sync_q[SYNC_STAGES-1];
            new_game_q <= new_game;
            frame_done <= 1'b0;
            if (ng_edge) begin
                hits       <= '0;
                shots      <= '0;
                game_ready <= 1'b0;
                pend_vld   <= 1'b0;
                ng_frame   <= 1'b1;
                frame_q    <= ng_snap;
                idx        <= 3'd0;
                out_tag    <= 3'd0;
                out_data   <= target_x;
                // From IDLE the frame starts now; otherwise spend one cycle with out_valid low.
                if (state == IDLE) begin
                    state     <= SEND;
                    out_valid <= 1'b1;
                    restart   <= 1'b0;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    restart   <= 1'b1;
                end
            end else begin
                if (result_valid) begin
                    hits  <= hits_inc;
                    shots <= shots_inc;
                end
                case (state)
                    IDLE: begin
                        if (restart) begin
                            restart   <= 1'b0;
                            state     <= SEND;
                            out_valid <= 1'b1;
                            if (result_valid) begin
                                pend_q   <= shot_snap;
                                pend_vld <= 1'b1;
                            end
                        end else if (result_valid) begin
                            state     <= SEND;
                            ng_frame  <= 1'b0;
                            frame_q   <= shot_snap;
                            idx       <= 3'd2;
                            out_tag   <= 3'd2;
                            out_data  <= shot_snap[2];
                            out_valid <= 1'b1;
                        end
                    end
                    SEND: begin
                        if (result_valid) begin
                            pend_q   <= shot_snap;
                            pend_vld <= 1'b1;
                        end
                        if (ack_edge) begin
                            if (idx == last_idx) begin
                                state      <= DONE;
                                out_valid  <= 1'b0;
                                frame_done <= 1'b1;
                                if (ng_frame) game_ready <= 1'b1;
                            end else begin
                                idx      <= idx + 3'd1;
                                out_tag  <= idx + 3'd1;
                                out_data <= frame_q[idx + 3'd1];
                            end
                        end
                    end
                    DONE: begin
                        // A shot landing in this very cycle is newer than the buffered one.
                        if (result_valid || pend_vld) begin
                            state     <= SEND;
                            pend_vld  <= 1'b0;
                            ng_frame  <= 1'b0;
                            frame_q   <= start_src;
                            idx       <= 3'd2;
                            out_tag   <= 3'd2;
                            out_data  <= start_src[2];
                            out_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rpt.out_data   = out_data;
    assign rpt.out_tag    = out_tag;
    assign rpt.out_valid  = out_valid;
    assign rpt.frame_done = frame_done;
    assign rpt.game_ready = game_ready;
`ifdef REPORT_PARITY_EN
    assign rpt.out_parity = out_valid & (^{out_tag, out_data});
`else
    assign rpt.out_parity = 1'b0;
`endif
endmodule
